// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with EX/MEM and MEM/WB registers and an
// internal word-organised, little-endian data memory.
//
// Ports:
//   Clock, Reset (sync, active-high), Stall, Flush  - pipeline control
//   *_In                                            - EX-stage controls/operands
//   FWFromMEM, RegDest_MEM, RegWrite_MEM,
//   MemRead_MEM                                     - registered EX/MEM view
//   MEM_ReadData                                    - extended load data in MEM
//   WB_Data, WB_RegDest, WB_RegWrite                - MEM/WB register
//   MisalignedErr                                   - sticky misaligned flag
module mem_stage #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        RegWrite_In,
    input  logic        MemRead_In,
    input  logic        MemWrite_In,
    input  logic        MemToReg_In,
    input  logic        MemSigned_In,
    input  logic [1:0]  MemSize_In,
    input  logic [4:0]  RegDest_In,
    input  logic [31:0] Result_In,
    input  logic [31:0] StoreData_In,
    output logic [31:0] FWFromMEM,
    output logic [31:0] MEM_ReadData,
    output logic [4:0]  RegDest_MEM,
    output logic        RegWrite_MEM,
    output logic        MemRead_MEM,
    output logic [31:0] WB_Data,
    output logic [4:0]  WB_RegDest,
    output logic        WB_RegWrite,
    output logic        MisalignedErr
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        SZ_WORD  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_BYTE  = 2'b10,
        SZ_WORDX = 2'b11
    } size_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        mem_signed;
        size_e       size;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_data;
    } exmem_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_write;
    } memwb_t;

    exmem_t ex_q, ex_d;
    memwb_t wb_q, wb_d;
    logic   mis_q, mis_d;

    // Zero at time 0; Reset deliberately leaves the contents alone.
    logic [31:0] mem_q [DEPTH] = '{default: '0};

    logic [31:0]   addr;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   rword;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_val;
    logic [31:0]   rdata;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          misaligned;
    logic          wr_en;

    // Address bits above the memory index are ignored (wrap modulo DEPTH).
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    assign addr  = ex_q.result;
    assign idx   = addr[AW+1:2];
    assign off   = addr[1:0];
    assign rword = mem_q[idx];

    always_comb begin
        ex_d = ex_q;
        if (Flush) begin
            ex_d = '0;
        end else if (!Stall) begin
            ex_d.reg_write  = RegWrite_In;
            ex_d.mem_read   = MemRead_In;
            ex_d.mem_write  = MemWrite_In;
            ex_d.mem_to_reg = MemToReg_In;
            ex_d.mem_signed = MemSigned_In;
            ex_d.size       = size_e'(MemSize_In);
            ex_d.rd         = RegDest_In;
            ex_d.result     = Result_In;
            ex_d.store_data = StoreData_In;
        end
    end

    // Store lanes replicate the operand so each byte enable picks the right slice.
    always_comb begin
        misaligned = 1'b0;
        be         = '1;
        wdata      = ex_q.store_data;
        ld_byte    = rword[{off, 3'b000} +: 8];
        ld_half    = off[1] ? rword[31:16] : rword[15:0];
        ld_val     = rword;
        case (ex_q.size)
            SZ_HALF: begin
                misaligned = off[0];
                be         = off[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{ex_q.store_data[15:0]}};
                ld_val     = {{16{ex_q.mem_signed & ld_half[15]}}, ld_half};
            end
            SZ_BYTE: begin
                be     = 4'b0001 << off;
                wdata  = {4{ex_q.store_data[7:0]}};
                ld_val = {{24{ex_q.mem_signed & ld_byte[7]}}, ld_byte};
            end
            default: begin
                misaligned = (off != 2'b00);
            end
        endcase
    end

    assign rdata = (ex_q.mem_read && !misaligned) ? ld_val : '0;
    assign wr_en = ex_q.mem_write && !Stall && !Reset && !misaligned;
    assign mis_d = mis_q | ((ex_q.mem_read | ex_q.mem_write) & misaligned);

    always_comb begin
        wb_d = wb_q;
        if (!Stall) begin
            wb_d.data      = ex_q.mem_to_reg ? rdata : ex_q.result;
            wb_d.rd        = ex_q.rd;
            wb_d.reg_write = ex_q.reg_write;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ex_q  <= '0;
            wb_q  <= '0;
            mis_q <= 1'b0;
        end else begin
            ex_q  <= ex_d;
            wb_q  <= wb_d;
            mis_q <= mis_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign FWFromMEM     = ex_q.result;
    assign MEM_ReadData  = rdata;
    assign RegDest_MEM   = ex_q.rd;
    assign RegWrite_MEM  = ex_q.reg_write;
    assign MemRead_MEM   = ex_q.mem_read;
    assign WB_Data       = wb_q.data;
    assign WB_RegDest    = wb_q.rd;
    assign WB_RegWrite   = wb_q.reg_write;
    assign MisalignedErr = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: table of instruction vectors pushed through a
// scoreboard (MEM-stage then WB-stage expectations), followed by hand-written
// misaligned, stall/flush and reset-mid-store sequences.
module tb_mem_stage;

    logic        Clock = 1'b0;
    logic        Reset, Stall, Flush;
    logic        RegWrite_In, MemRead_In, MemWrite_In, MemToReg_In, MemSigned_In;
    logic [1:0]  MemSize_In;
    logic [4:0]  RegDest_In;
    logic [31:0] Result_In, StoreData_In;
    logic [31:0] FWFromMEM, MEM_ReadData, WB_Data;
    logic [4:0]  RegDest_MEM, WB_RegDest;
    logic        RegWrite_MEM, MemRead_MEM, WB_RegWrite, MisalignedErr;

    always #5 Clock = ~Clock;

    mem_stage #(.DEPTH(1024)) dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .RegWrite_In(RegWrite_In), .MemRead_In(MemRead_In),
        .MemWrite_In(MemWrite_In), .MemToReg_In(MemToReg_In),
        .MemSigned_In(MemSigned_In), .MemSize_In(MemSize_In),
        .RegDest_In(RegDest_In), .Result_In(Result_In),
        .StoreData_In(StoreData_In), .FWFromMEM(FWFromMEM),
        .MEM_ReadData(MEM_ReadData), .RegDest_MEM(RegDest_MEM),
        .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM),
        .WB_Data(WB_Data), .WB_RegDest(WB_RegDest),
        .WB_RegWrite(WB_RegWrite), .MisalignedErr(MisalignedErr)
    );

    typedef struct {
        int          id;
        logic        rw, mr, mw, m2r, sgn;
        logic [1:0]  sz;
        logic [4:0]  rd;
        logic [31:0] addr, sd, want_rd;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    vec_t vecs[$];
    vec_t memq[$];
    vec_t wbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, want);
        end
    endtask

    function automatic vec_t ld(input logic [1:0] sz, input logic sgn, input logic [4:0] rd,
                                input logic [31:0] a, input logic [31:0] want);
        vec_t v;
        v.id = 0; v.rw = 1'b1; v.mr = 1'b1; v.mw = 1'b0; v.m2r = 1'b1; v.sgn = sgn;
        v.sz = sz; v.rd = rd; v.addr = a; v.sd = '0; v.want_rd = want;
        return v;
    endfunction

    function automatic vec_t st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        vec_t v;
        v.id = 0; v.rw = 1'b0; v.mr = 1'b0; v.mw = 1'b1; v.m2r = 1'b0; v.sgn = 1'b0;
        v.sz = sz; v.rd = '0; v.addr = a; v.sd = d; v.want_rd = '0;
        return v;
    endfunction

    function automatic vec_t alu(input logic [4:0] rd, input logic [31:0] val);
        vec_t v;
        v.id = 0; v.rw = 1'b1; v.mr = 1'b0; v.mw = 1'b0; v.m2r = 1'b0; v.sgn = 1'b0;
        v.sz = 2'b00; v.rd = rd; v.addr = val; v.sd = '0; v.want_rd = '0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        RegWrite_In = v.rw; MemRead_In = v.mr; MemWrite_In = v.mw;
        MemToReg_In = v.m2r; MemSigned_In = v.sgn; MemSize_In = v.sz;
        RegDest_In = v.rd; Result_In = v.addr; StoreData_In = v.sd;
    endtask

    task automatic idle();
        RegWrite_In = 1'b0; MemRead_In = 1'b0; MemWrite_In = 1'b0;
        MemToReg_In = 1'b0; MemSigned_In = 1'b0; MemSize_In = 2'b00;
        RegDest_In = '0; Result_In = '0; StoreData_In = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".fw"},    FWFromMEM,     32'h0);
        chk({tag, ".rdata"}, MEM_ReadData,  32'h0);
        chk({tag, ".rdmem"}, RegDest_MEM,   32'h0);
        chk({tag, ".rwmem"}, RegWrite_MEM,  32'h0);
        chk({tag, ".mrmem"}, MemRead_MEM,   32'h0);
        chk({tag, ".wbd"},   WB_Data,       32'h0);
        chk({tag, ".wbrd"},  WB_RegDest,    32'h0);
        chk({tag, ".wbwe"},  WB_RegWrite,   32'h0);
        chk({tag, ".mis"},   MisalignedErr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e, w;
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        idle();
        tick(); tick();
        chk_all_zero("reset");
        Reset = 1'b0;

        // Expected load data derived by hand from the store sequence.
        vecs.push_back(st(2'b00, 32'h10, 32'hDEADBEEF));
        vecs.push_back(ld(2'b00, 1'b0, 5'd5,  32'h10, 32'hDEADBEEF));
        vecs.push_back(st(2'b10, 32'h13, 32'h00000080));
        vecs.push_back(ld(2'b10, 1'b1, 5'd6,  32'h13, 32'hFFFFFF80));
        vecs.push_back(ld(2'b10, 1'b0, 5'd7,  32'h13, 32'h00000080));
        vecs.push_back(ld(2'b00, 1'b0, 5'd8,  32'h10, 32'h80ADBEEF));
        vecs.push_back(ld(2'b01, 1'b1, 5'd9,  32'h12, 32'hFFFF80AD));
        vecs.push_back(ld(2'b01, 1'b0, 5'd10, 32'h10, 32'h0000BEEF));
        vecs.push_back(ld(2'b10, 1'b1, 5'd11, 32'h10, 32'hFFFFFFEF));
        vecs.push_back(st(2'b01, 32'h22, 32'hFFFF1234));
        vecs.push_back(ld(2'b00, 1'b0, 5'd12, 32'h20, 32'h12340000));
        vecs.push_back(st(2'b00, 32'h1000, 32'hCAFEF00D));
        vecs.push_back(ld(2'b00, 1'b0, 5'd13, 32'h0, 32'hCAFEF00D));
        vecs.push_back(alu(5'd14, 32'h55AA55AA));
        vecs.push_back(ld(2'b00, 1'b0, 5'd15, 32'h1010, 32'h80ADBEEF));
        vecs.push_back(ld(2'b11, 1'b0, 5'd16, 32'h20, 32'h12340000));
        vecs.push_back(ld(2'b10, 1'b1, 5'd17, 32'h23, 32'h00000012));

        for (int i = 0; i <= vecs.size(); i++) begin
            if (i < vecs.size()) begin
                e = vecs[i];
                e.id = i;
                drive(e);
                memq.push_back(e);
            end else begin
                idle();
            end
            tick();
            if (wbq.size() != 0) begin
                w = wbq.pop_front();
                chk($sformatf("v%0d.wbd", w.id),  WB_Data,     w.m2r ? w.want_rd : w.addr);
                chk($sformatf("v%0d.wbrd", w.id), WB_RegDest,  w.rd);
                chk($sformatf("v%0d.wbwe", w.id), WB_RegWrite, w.rw);
            end
            if (memq.size() != 0) begin
                e = memq.pop_front();
                chk($sformatf("v%0d.rdata", e.id), MEM_ReadData, e.want_rd);
                chk($sformatf("v%0d.fw", e.id),    FWFromMEM,    e.addr);
                chk($sformatf("v%0d.rdmem", e.id), RegDest_MEM,  e.rd);
                chk($sformatf("v%0d.rwmem", e.id), RegWrite_MEM, e.rw);
                chk($sformatf("v%0d.mrmem", e.id), MemRead_MEM,  e.mr);
                chk($sformatf("v%0d.mis", e.id),   MisalignedErr, 1'b0);
                wbq.push_back(e);
            end
        end

        // Misaligned load: no data, flag on the following edge.
        drive(ld(2'b01, 1'b0, 5'd22, 32'h11, 32'h0));
        tick();
        idle();
        chk("mis_ld.rdata", MEM_ReadData, 32'h0);
        chk("mis_ld.flag_before", MisalignedErr, 1'b0);
        tick();
        chk("mis_ld.flag", MisalignedErr, 1'b1);

        // Reset clears the flag but keeps memory.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst.mis_clear", MisalignedErr, 1'b0);

        // Misaligned word store: word unchanged, sticky flag.
        drive(st(2'b00, 32'h12, 32'h11111111));
        tick();
        idle();
        chk("mis_st.flag_before", MisalignedErr, 1'b0);
        tick();
        chk("mis_st.flag", MisalignedErr, 1'b1);
        drive(ld(2'b00, 1'b0, 5'd24, 32'h10, 32'h0));
        tick();
        idle();
        chk("mis_st.word", MEM_ReadData, 32'h80ADBEEF);
        for (int k = 0; k < 5; k++) tick();
        chk("mis_st.sticky", MisalignedErr, 1'b1);

        // Store held under a 3-cycle stall while EX presents a different op.
        drive(alu(5'd19, 32'h77));
        tick();
        drive(st(2'b00, 32'h30, 32'hA5A5A5A5));
        tick();
        chk("stall.wb_pre", WB_Data, 32'h77);
        drive(ld(2'b00, 1'b0, 5'd20, 32'h30, 32'h0));
        StoreData_In = '1;
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d.wbd", k),  WB_Data,      32'h77);
            chk($sformatf("stall%0d.wbrd", k), WB_RegDest,   5'd19);
            chk($sformatf("stall%0d.wbwe", k), WB_RegWrite,  1'b1);
            chk($sformatf("stall%0d.fw", k),   FWFromMEM,    32'h30);
            chk($sformatf("stall%0d.mr", k),   MemRead_MEM,  1'b0);
        end
        Stall = 1'b0;
        StoreData_In = '0;
        tick();
        idle();
        chk("stall.ld_rdata", MEM_ReadData, 32'hA5A5A5A5);
        chk("stall.wb_store", WB_Data, 32'h30);
        tick();
        chk("stall.ld_wbd",  WB_Data,     32'hA5A5A5A5);
        chk("stall.ld_wbrd", WB_RegDest,  5'd20);
        chk("stall.ld_wbwe", WB_RegWrite, 1'b1);

        // Flush beats Stall: bubble in EX/MEM.
        drive(alu(5'd21, 32'h99));
        Stall = 1'b1;
        Flush = 1'b1;
        tick();
        Stall = 1'b0;
        Flush = 1'b0;
        idle();
        chk("flush.rwmem", RegWrite_MEM, 1'b0);
        chk("flush.rdmem", RegDest_MEM,  5'd0);
        chk("flush.fw",    FWFromMEM,    32'h0);
        chk("flush.mrmem", MemRead_MEM,  1'b0);

        // Reset while a store sits in MEM: store dropped, outputs cleared.
        drive(st(2'b00, 32'h40, 32'h0BADF00D));
        tick();
        idle();
        Reset = 1'b1;
        tick();
        chk_all_zero("rst_mid");
        Reset = 1'b0;
        drive(ld(2'b00, 1'b0, 5'd23, 32'h40, 32'h0));
        tick();
        idle();
        chk("rst_mid.mem", MEM_ReadData, 32'h0);
        chk("rst_mid.mr",  MemRead_MEM,  1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
